// File: rtl/s32x_pwm_player_pkg.sv
// Shared constants, routing encoding and helpers for the 32X PWM playback path.
package s32x_pwm_player_pkg;

  localparam int PWM_FIFO_DEPTH = 3;
  localparam int PWM_PW_W       = 12;

  localparam logic [PWM_PW_W-1:0] PWM_CYCR_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    PWM_OFF  = 2'b00,
    PWM_SAME = 2'b01,
    PWM_SWAP = 2'b10,
    PWM_INV  = 2'b11
  } pwm_route_t;

  // CYCR of 0 or 1 selects the longest period the counter can express.
  function automatic logic [PWM_PW_W-1:0] pwm_period(input logic [PWM_PW_W-1:0] cycr);
    return (cycr <= PWM_PW_W'(1)) ? PWM_CYCR_MAX : cycr - PWM_PW_W'(1);
  endfunction

  function automatic logic [PWM_PW_W-1:0] pwm_route(input pwm_route_t md,
                                                     input logic [PWM_PW_W-1:0] same_val,
                                                     input logic [PWM_PW_W-1:0] swap_val);
    case (md)
      PWM_SAME: return same_val;
      PWM_SWAP: return swap_val;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/s32x_pwm_player_if.sv
// Register-side push strobes and FIFO status between the system register file and the PWM player.
interface s32x_pwm_player_if
  import s32x_pwm_player_pkg::*;
#(
  parameter int W = PWM_PW_W
);

  logic         LCH_WR;
  logic         RCH_WR;
  logic         MONO_WR;
  logic [W-1:0] WDATA;
  logic         L_FULL;
  logic         L_EMPTY;
  logic         R_FULL;
  logic         R_EMPTY;
  logic         M_FULL;
  logic         M_EMPTY;

  modport master (
    output LCH_WR, RCH_WR, MONO_WR, WDATA,
    input  L_FULL, L_EMPTY, R_FULL, R_EMPTY, M_FULL, M_EMPTY
  );

  modport slave (
    input  LCH_WR, RCH_WR, MONO_WR, WDATA,
    output L_FULL, L_EMPTY, R_FULL, R_EMPTY, M_FULL, M_EMPTY
  );

endinterface

// File: rtl/s32x_pwm_fifo.sv
// Small circular sample FIFO; a push into a full FIFO is kept only when a pop frees a slot that cycle.
module s32x_pwm_fifo
  import s32x_pwm_player_pkg::*;
#(
  parameter int DEPTH = PWM_FIFO_DEPTH,
  parameter int W     = PWM_PW_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (do_pop)  rptr_d = ptr_inc(rptr_q);
    if (do_push) wptr_d = ptr_inc(wptr_q);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: sample storage is not reset; the occupancy counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/s32x_pwm_player.sv
// PWM playback: period counter, per-period FIFO pops, L/R routing, pulse outputs and the period timer interrupt.
module s32x_pwm_player
  import s32x_pwm_player_pkg::*;
#(
  parameter int FIFO_DEPTH = PWM_FIFO_DEPTH,
  parameter int PW_W       = PWM_PW_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic [1:0]         LMD,
  input  logic [1:0]         RMD,
  input  logic [3:0]         TM,
  input  logic [PW_W-1:0]    CYCR,
  s32x_pwm_player_if.slave   bus,
  output logic [PW_W-1:0]    L_OUT,
  output logic [PW_W-1:0]    R_OUT,
  output logic               PWM_L,
  output logic               PWM_R,
  output logic               PWM_INT
);

  logic [PW_W-1:0] cnt_q, cnt_d;
  logic [PW_W-1:0] plen_q, plen_d;
  logic [PW_W-1:0] plen_cur;
  logic [4:0]      tcnt_q, tcnt_d;
  logic [PW_W-1:0] lval_q, lval_d, rval_q, rval_d;
  logic [PW_W-1:0] l_out_q, l_out_d, r_out_q, r_out_d;
  logic            pe_q, pe_d;
  logic            pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
  logic            int_q, int_d;

  logic            active, tick, period_end;
  logic            l_push, r_push;
  logic            l_full, l_empty, r_full, r_empty;
  logic [PW_W-1:0] l_rdata, r_rdata;

  assign active     = (pwm_route_t'(LMD) != PWM_OFF) || (pwm_route_t'(RMD) != PWM_OFF);
  assign tick       = CE && active;
  // The period length is captured on the first tick of each period, so CYCR edits land next period.
  assign plen_cur   = (cnt_q == '0) ? pwm_period(CYCR) : plen_q;
  assign period_end = tick && (cnt_q == plen_cur - PW_W'(1));

  assign l_push = bus.LCH_WR | bus.MONO_WR;
  assign r_push = bus.RCH_WR | bus.MONO_WR;

  s32x_pwm_fifo #(.DEPTH(FIFO_DEPTH), .W(PW_W)) u_fifo_l (
    .clk   (CLK),
    .rst   (RST),
    .push  (l_push),
    .pop   (period_end),
    .wdata (bus.WDATA),
    .rdata (l_rdata),
    .full  (l_full),
    .empty (l_empty)
  );

  s32x_pwm_fifo #(.DEPTH(FIFO_DEPTH), .W(PW_W)) u_fifo_r (
    .clk   (CLK),
    .rst   (RST),
    .push  (r_push),
    .pop   (period_end),
    .wdata (bus.WDATA),
    .rdata (r_rdata),
    .full  (r_full),
    .empty (r_empty)
  );

  always_comb begin
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    tcnt_d  = tcnt_q;
    int_d   = 1'b0;
    lval_d  = lval_q;
    rval_d  = rval_q;
    pe_d    = period_end;

    if (tick) begin
      plen_d = plen_cur;
      cnt_d  = period_end ? '0 : cnt_q + PW_W'(1);
    end

    if (period_end) begin
      if (!l_empty) lval_d = l_rdata;
      if (!r_empty) rval_d = r_rdata;
      if (tcnt_q <= 5'd1) begin
        int_d  = 1'b1;
        tcnt_d = (TM == 4'd0) ? 5'd16 : {1'b0, TM};
      end else begin
        tcnt_d = tcnt_q - 5'd1;
      end
    end

    // Routing follows the pop by one cycle and reads the freshly latched samples.
    l_out_d = pe_q ? pwm_route(pwm_route_t'(LMD), lval_q, rval_q) : l_out_q;
    r_out_d = pe_q ? pwm_route(pwm_route_t'(RMD), rval_q, lval_q) : r_out_q;

    pwm_l_d = (cnt_q < l_out_q);
    pwm_r_d = (cnt_q < r_out_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      plen_q  <= PWM_CYCR_MAX;
      tcnt_q  <= '0;
      int_q   <= 1'b0;
      lval_q  <= '0;
      rval_q  <= '0;
      pe_q    <= 1'b0;
      l_out_q <= '0;
      r_out_q <= '0;
      pwm_l_q <= 1'b0;
      pwm_r_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      tcnt_q  <= tcnt_d;
      int_q   <= int_d;
      lval_q  <= lval_d;
      rval_q  <= rval_d;
      pe_q    <= pe_d;
      l_out_q <= l_out_d;
      r_out_q <= r_out_d;
      pwm_l_q <= pwm_l_d;
      pwm_r_q <= pwm_r_d;
    end
  end

  assign L_OUT   = l_out_q;
  assign R_OUT   = r_out_q;
  assign PWM_L   = pwm_l_q;
  assign PWM_R   = pwm_r_q;
  assign PWM_INT = int_q;

  assign bus.L_FULL  = l_full;
  assign bus.L_EMPTY = l_empty;
  assign bus.R_FULL  = r_full;
  assign bus.R_EMPTY = r_empty;
  assign bus.M_FULL  = l_full | r_full;
  assign bus.M_EMPTY = l_empty & r_empty;

endmodule

// File: tb/tb_s32x_pwm_player.sv
// Bench for s32x_pwm_player: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_s32x_pwm_player;
  import s32x_pwm_player_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, CE;
  logic [1:0]  LMD, RMD;
  logic [3:0]  TM;
  logic [11:0] CYCR;
  logic [11:0] L_OUT, R_OUT;
  logic        PWM_L, PWM_R, PWM_INT;

  int n_checks = 0;
  int n_fail   = 0;

  s32x_pwm_player_if bus ();

  s32x_pwm_player dut (
    .CLK     (CLK),
    .RST     (RST),
    .CE      (CE),
    .LMD     (LMD),
    .RMD     (RMD),
    .TM      (TM),
    .CYCR    (CYCR),
    .bus     (bus),
    .L_OUT   (L_OUT),
    .R_OUT   (R_OUT),
    .PWM_L   (PWM_L),
    .PWM_R   (PWM_R),
    .PWM_INT (PWM_INT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Reference model: queues for the FIFOs, integers for counters, stepped on every rising edge.
  int mq_l[$];
  int mq_r[$];
  int m_cnt = 0, m_plen = 0, m_tcnt = 0;
  int m_lval = 0, m_rval = 0, m_lout = 0, m_rout = 0;
  bit m_pwml = 0, m_pwmr = 0, m_int = 0, m_pe_prev = 0;
  bit m_tick, m_pe;

  function automatic int route(int md, int same_v, int swap_v);
    if (md == 1) return same_v;
    if (md == 2) return swap_v;
    return 0;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      mq_l.delete();
      mq_r.delete();
      m_cnt = 0; m_plen = 0; m_tcnt = 0;
      m_lval = 0; m_rval = 0; m_lout = 0; m_rout = 0;
      m_pwml = 0; m_pwmr = 0; m_int = 0; m_pe_prev = 0;
    end else begin
      m_tick = CE && (LMD != 2'd0 || RMD != 2'd0);
      if (m_tick && m_cnt == 0) m_plen = (CYCR <= 12'd1) ? 4095 : int'(CYCR) - 1;
      m_pe = m_tick && (m_cnt == m_plen - 1);
      m_pwml = (m_cnt < m_lout);
      m_pwmr = (m_cnt < m_rout);
      if (m_pe_prev) begin
        m_lout = route(int'(LMD), m_lval, m_rval);
        m_rout = route(int'(RMD), m_rval, m_lval);
      end
      m_int = m_pe && (m_tcnt <= 1);
      if (m_pe) m_tcnt = (m_tcnt <= 1) ? ((TM == 4'd0) ? 16 : int'(TM)) : m_tcnt - 1;
      if (m_pe && mq_l.size() > 0) m_lval = mq_l.pop_front();
      if (m_pe && mq_r.size() > 0) m_rval = mq_r.pop_front();
      if ((bus.LCH_WR || bus.MONO_WR) && mq_l.size() < 3) mq_l.push_back(int'(bus.WDATA));
      if ((bus.RCH_WR || bus.MONO_WR) && mq_r.size() < 3) mq_r.push_back(int'(bus.WDATA));
      if (m_tick) m_cnt = m_pe ? 0 : m_cnt + 1;
      m_pe_prev = m_pe;
    end
  end

  task automatic push(input bit l, input bit r, input bit m, input logic [11:0] d);
    bus.LCH_WR = l; bus.RCH_WR = r; bus.MONO_WR = m; bus.WDATA = d;
    @(negedge CLK);
    bus.LCH_WR = 1'b0; bus.RCH_WR = 1'b0; bus.MONO_WR = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'b0; LMD = 2'd0; RMD = 2'd0; TM = 4'd0; CYCR = 12'h011;
    bus.LCH_WR = 1'b0; bus.RCH_WR = 1'b0; bus.MONO_WR = 1'b0; bus.WDATA = '0;
    repeat (2) @(negedge CLK);
    n_checks++; if (bus.L_EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_l_empty: got %b want 1", bus.L_EMPTY); end
    n_checks++; if (bus.R_EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_r_empty: got %b want 1", bus.R_EMPTY); end
    n_checks++; if (bus.L_FULL !== 1'b0) begin n_fail++; $display("FAIL reset_l_full: got %b want 0", bus.L_FULL); end
    n_checks++; if (bus.M_EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_m_empty: got %b want 1", bus.M_EMPTY); end
    n_checks++; if (L_OUT !== 12'h000 || R_OUT !== 12'h000) begin n_fail++; $display("FAIL reset_outs: got %h/%h want 000/000", L_OUT, R_OUT); end
    n_checks++; if (PWM_INT !== 1'b0 || PWM_L !== 1'b0 || PWM_R !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got int=%b l=%b r=%b want 0", PWM_INT, PWM_L, PWM_R); end
    RST = 1'b0;
  endtask

  task automatic test_fill_drop();
    int vals[$];
    int when[$];
    logic [11:0] last;
    CE = 1'b0; LMD = 2'd0; RMD = 2'd0; CYCR = 12'h011;
    push(0, 0, 1, 12'h100);
    push(0, 0, 1, 12'h200);
    n_checks++; if (bus.M_FULL !== 1'b0) begin n_fail++; $display("FAIL fill_two_not_full: got %b want 0", bus.M_FULL); end
    push(0, 0, 1, 12'h300);
    n_checks++; if (bus.M_FULL !== 1'b1 || bus.L_FULL !== 1'b1 || bus.R_FULL !== 1'b1) begin n_fail++; $display("FAIL fill_three_full: got m=%b l=%b r=%b want 1", bus.M_FULL, bus.L_FULL, bus.R_FULL); end
    push(0, 0, 1, 12'h400);
    n_checks++; if (bus.M_FULL !== 1'b1) begin n_fail++; $display("FAIL fill_drop_full: got %b want 1", bus.M_FULL); end
    LMD = 2'd1; RMD = 2'd1; CE = 1'b1;
    last = L_OUT;
    for (int c = 1; c <= 120; c++) begin
      @(negedge CLK);
      if (L_OUT !== last) begin
        vals.push_back(int'(L_OUT));
        when.push_back(c);
        n_checks++; if (R_OUT !== L_OUT) begin n_fail++; $display("FAIL fill_r_follows_l: got %h want %h", R_OUT, L_OUT); end
        last = L_OUT;
      end
    end
    n_checks++;
    if (vals.size() != 3) begin
      n_fail++; $display("FAIL fill_sample_count: got %0d want 3", vals.size());
    end else begin
      if (vals[0] != 'h100 || vals[1] != 'h200 || vals[2] != 'h300) begin n_fail++; $display("FAIL fill_sequence: got %h %h %h want 100 200 300", vals[0], vals[1], vals[2]); end
      n_checks++; if (when[0] != 17) begin n_fail++; $display("FAIL fill_first_latency: got %0d want 17", when[0]); end
      n_checks++; if (when[1] - when[0] != 16 || when[2] - when[1] != 16) begin n_fail++; $display("FAIL fill_spacing: got %0d,%0d want 16,16", when[1] - when[0], when[2] - when[1]); end
    end
    n_checks++; if (bus.L_EMPTY !== 1'b1 || bus.R_EMPTY !== 1'b1 || L_OUT !== 12'h300) begin n_fail++; $display("FAIL fill_hold: got empty=%b%b out=%h want 11 300", bus.L_EMPTY, bus.R_EMPTY, L_OUT); end
  endtask

  task automatic test_swap_routing();
    bit found = 1'b0;
    int hi_l = 0, hi_r = 0;
    CE = 1'b0;
    push(1, 0, 0, 12'h050);
    push(0, 1, 0, 12'h0A0);
    CYCR = 12'h101; LMD = 2'd2; RMD = 2'd2; CE = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      if (L_OUT === 12'h0A0) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL swap_left: got %h want 0a0", L_OUT); end
    n_checks++; if (R_OUT !== 12'h050) begin n_fail++; $display("FAIL swap_right: got %h want 050", R_OUT); end
    repeat (4) @(negedge CLK);
    repeat (256) begin
      @(negedge CLK);
      hi_l += int'(PWM_L);
      hi_r += int'(PWM_R);
    end
    n_checks++; if (hi_l != 160) begin n_fail++; $display("FAIL swap_pwm_l_duty: got %0d want 160", hi_l); end
    n_checks++; if (hi_r != 80) begin n_fail++; $display("FAIL swap_pwm_r_duty: got %0d want 80", hi_r); end
  endtask

  task automatic test_full_pop();
    int vals[$];
    logic [11:0] last;
    CE = 1'b0; LMD = 2'd1; RMD = 2'd1; CYCR = 12'h011; TM = 4'd0;
    do_reset();
    push(1, 0, 0, 12'h011);
    push(1, 0, 0, 12'h022);
    push(1, 0, 0, 12'h033);
    n_checks++; if (bus.L_FULL !== 1'b1 || bus.R_EMPTY !== 1'b1) begin n_fail++; $display("FAIL fullpop_setup: got lfull=%b rempty=%b want 1 1", bus.L_FULL, bus.R_EMPTY); end
    CE = 1'b1;
    repeat (15) @(negedge CLK);
    push(1, 0, 0, 12'h044);
    n_checks++; if (bus.L_FULL !== 1'b1) begin n_fail++; $display("FAIL fullpop_stays_full: got %b want 1", bus.L_FULL); end
    last = L_OUT;
    for (int c = 0; c < 80; c++) begin
      @(negedge CLK);
      if (L_OUT !== last) begin vals.push_back(int'(L_OUT)); last = L_OUT; end
    end
    n_checks++;
    if (vals.size() != 4) begin
      n_fail++; $display("FAIL fullpop_count: got %0d want 4", vals.size());
    end else if (vals[0] != 'h011 || vals[1] != 'h022 || vals[2] != 'h033 || vals[3] != 'h044) begin
      n_fail++; $display("FAIL fullpop_order: got %h %h %h %h want 011 022 033 044", vals[0], vals[1], vals[2], vals[3]);
    end
  endtask

  task automatic test_timer();
    int t[$];
    bit prev;
    int pulses;
    CE = 1'b0; LMD = 2'd1; RMD = 2'd1; CYCR = 12'h011; TM = 4'd3;
    do_reset();
    CE = 1'b1; prev = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge CLK);
      if (PWM_INT === 1'b1) begin
        t.push_back(c);
        n_checks++; if (prev) begin n_fail++; $display("FAIL timer_width: got 2+ cycles want 1 at %0d", c); end
      end
      prev = PWM_INT;
    end
    n_checks++;
    if (t.size() != 4) begin n_fail++; $display("FAIL timer_tm3_count: got %0d want 4", t.size()); end
    else if (t[0] != 16 || t[1] - t[0] != 48 || t[2] - t[1] != 48 || t[3] - t[2] != 48) begin
      n_fail++; $display("FAIL timer_tm3_spacing: got %0d %0d %0d %0d want 16 64 112 160", t[0], t[1], t[2], t[3]);
    end

    t.delete();
    CE = 1'b0; TM = 4'd0;
    do_reset();
    CE = 1'b1;
    for (int c = 1; c <= 800; c++) begin
      @(negedge CLK);
      if (PWM_INT === 1'b1) t.push_back(c);
    end
    n_checks++;
    if (t.size() != 4) begin n_fail++; $display("FAIL timer_tm0_count: got %0d want 4", t.size()); end
    else if (t[1] - t[0] != 256 || t[2] - t[1] != 256 || t[3] - t[2] != 256) begin
      n_fail++; $display("FAIL timer_tm0_spacing: got %0d %0d %0d want 256 256 256", t[1] - t[0], t[2] - t[1], t[3] - t[2]);
    end

    LMD = 2'd0; RMD = 2'd0; pulses = 0;
    repeat (600) begin
      @(negedge CLK);
      if (PWM_INT === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL timer_off: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    CE = 1'b0; LMD = 2'd1; RMD = 2'd1; CYCR = 12'h011; TM = 4'd3;
    do_reset();
    push(0, 0, 1, 12'h100);
    push(0, 0, 1, 12'h200);
    push(0, 0, 1, 12'h300);
    CE = 1'b1;
    repeat (23) @(negedge CLK);
    n_checks++; if (PWM_L !== 1'b1 || L_OUT !== 12'h100) begin n_fail++; $display("FAIL midrst_before: got pwm=%b out=%h want 1 100", PWM_L, L_OUT); end
    RST = 1'b1;
    @(negedge CLK);
    n_checks++; if (bus.L_EMPTY !== 1'b1 || bus.R_EMPTY !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b%b want 11", bus.L_EMPTY, bus.R_EMPTY); end
    n_checks++; if (PWM_L !== 1'b0 || L_OUT !== 12'h000 || PWM_INT !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got pwm=%b out=%h int=%b want 0 000 0", PWM_L, L_OUT, PWM_INT); end
    RST = 1'b0;
    while (k < 100) begin
      @(negedge CLK);
      k++;
      if (PWM_INT === 1'b1) break;
    end
    n_checks++; if (k != 16) begin n_fail++; $display("FAIL midrst_restart: got first period end after %0d ticks want 16", k); end
  endtask

  task automatic test_cycr_max();
    int k = 0;
    CE = 1'b0; LMD = 2'd1; RMD = 2'd0; CYCR = 12'h000; TM = 4'd0;
    do_reset();
    CE = 1'b1;
    while (k < 5000) begin
      @(negedge CLK);
      k++;
      if (PWM_INT === 1'b1) break;
    end
    n_checks++; if (k != 4095) begin n_fail++; $display("FAIL cycr_zero_period: got %0d want 4095", k); end
  endtask

  task automatic test_random();
    logic [5:0] exp_stat;
    CE = 1'b0; LMD = 2'd1; RMD = 2'd2; CYCR = 12'h005; TM = 4'd2;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      exp_stat = {mq_l.size() == 3, mq_l.size() == 0, mq_r.size() == 3, mq_r.size() == 0,
                  (mq_l.size() == 3) || (mq_r.size() == 3), (mq_l.size() == 0) && (mq_r.size() == 0)};
      n_checks++; if ({bus.L_FULL, bus.L_EMPTY, bus.R_FULL, bus.R_EMPTY, bus.M_FULL, bus.M_EMPTY} !== exp_stat) begin n_fail++; $display("FAIL rand_status[%0d]: got %b want %b", i, {bus.L_FULL, bus.L_EMPTY, bus.R_FULL, bus.R_EMPTY, bus.M_FULL, bus.M_EMPTY}, exp_stat); end
      n_checks++; if (L_OUT !== 12'(m_lout)) begin n_fail++; $display("FAIL rand_l_out[%0d]: got %h want %h", i, L_OUT, 12'(m_lout)); end
      n_checks++; if (R_OUT !== 12'(m_rout)) begin n_fail++; $display("FAIL rand_r_out[%0d]: got %h want %h", i, R_OUT, 12'(m_rout)); end
      n_checks++; if ({PWM_L, PWM_R} !== {m_pwml, m_pwmr}) begin n_fail++; $display("FAIL rand_pwm[%0d]: got %b%b want %b%b", i, PWM_L, PWM_R, m_pwml, m_pwmr); end
      n_checks++; if (PWM_INT !== m_int) begin n_fail++; $display("FAIL rand_int[%0d]: got %b want %b", i, PWM_INT, m_int); end

      RST         = ($urandom_range(0, 999) == 0);
      CE          = ($urandom_range(0, 9) < 8);
      bus.LCH_WR  = ($urandom_range(0, 7) == 0);
      bus.RCH_WR  = ($urandom_range(0, 7) == 0);
      bus.MONO_WR = ($urandom_range(0, 9) == 0);
      bus.WDATA   = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 24)) : 12'($urandom);
      if ($urandom_range(0, 149) == 0) LMD = 2'($urandom);
      if ($urandom_range(0, 149) == 0) RMD = 2'($urandom);
      if ($urandom_range(0, 59) == 0)  CYCR = 12'($urandom_range(2, 24));
      if ($urandom_range(0, 99) == 0)  TM = 4'($urandom);
    end
    RST = 1'b0; bus.LCH_WR = 1'b0; bus.RCH_WR = 1'b0; bus.MONO_WR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drop();
    test_swap_routing();
    test_full_pop();
    test_timer();
    test_reset_mid();
    test_cycr_max();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
